// File: rtl/wb_decode.sv
// Wishbone B3 address decoder: one master fanned out to SLAVES slaves,
// with decode-error and watchdog-timeout termination.
module wb_decode #(
  parameter int SLAVES     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH*SLAVES-1:0] S_BASE = '0,
  parameter logic [ADDR_WIDTH*SLAVES-1:0] S_MASK = '0,
  parameter int TIMEOUT    = 255,
  localparam int SEL_WIDTH = DATA_WIDTH >> 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ADDR_WIDTH-1:0]        m_adr_i,
  input  logic [DATA_WIDTH-1:0]        m_dat_i,
  input  logic [SEL_WIDTH-1:0]         m_sel_i,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  input  logic                         m_we_i,
  input  logic [2:0]                   m_cti_i,
  input  logic [1:0]                   m_bte_i,
  output logic [DATA_WIDTH-1:0]        m_dat_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic                         m_rty_o,
  output logic [ADDR_WIDTH*SLAVES-1:0] s_adr_o,
  output logic [DATA_WIDTH*SLAVES-1:0] s_dat_o,
  output logic [SEL_WIDTH*SLAVES-1:0]  s_sel_o,
  output logic [SLAVES-1:0]            s_we_o,
  output logic [3*SLAVES-1:0]          s_cti_o,
  output logic [2*SLAVES-1:0]          s_bte_o,
  output logic [SLAVES-1:0]            s_cyc_o,
  output logic [SLAVES-1:0]            s_stb_o,
  input  logic [DATA_WIDTH*SLAVES-1:0] s_dat_i,
  input  logic [SLAVES-1:0]            s_ack_i,
  input  logic [SLAVES-1:0]            s_err_i,
  input  logic [SLAVES-1:0]            s_rty_i,
  output logic                         timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DECERR,
    ABORT
  } state_t;

  state_t            r_state;
  logic [SLAVES-1:0] r_sel_q;
  logic [CW-1:0]     r_cnt;

  logic [SLAVES-1:0]     w_hit;
  logic [SLAVES-1:0]     w_dec;
  logic [SLAVES-1:0]     w_sel;
  logic                  w_req;
  logic                  w_ack;
  logic                  w_err;
  logic                  w_rty;
  logic                  w_resp;
  logic                  w_fire;
  logic                  w_berr;
  logic [DATA_WIDTH-1:0] w_dat;

  assign s_adr_o = {SLAVES{m_adr_i}};
  assign s_dat_o = {SLAVES{m_dat_i}};
  assign s_sel_o = {SLAVES{m_sel_i}};
  assign s_we_o  = {SLAVES{m_we_i}};
  assign s_cti_o = {SLAVES{m_cti_i}};
  assign s_bte_o = {SLAVES{m_bte_i}};

  assign w_req = m_cyc_i & m_stb_i;

  // Lowest index wins on overlapping windows.
  always_comb begin
    w_hit = '0;
    w_dec = '0;
    for (int j = 0; j < SLAVES; j++) begin
      w_hit[j] = ((m_adr_i ^ S_BASE[j*ADDR_WIDTH +: ADDR_WIDTH])
                 & S_MASK[j*ADDR_WIDTH +: ADDR_WIDTH]) == '0;
    end
    for (int j = SLAVES - 1; j >= 0; j--) begin
      if (w_hit[j]) begin
        w_dec    = '0;
        w_dec[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    unique case (r_state)
      IDLE:    w_sel = w_dec;
      BUSY:    w_sel = r_sel_q;
      DECERR:  w_sel = '0;
      ABORT:   w_sel = '0;
      default: w_sel = '0;
    endcase
  end

  always_comb begin
    w_ack = 1'b0;
    w_err = 1'b0;
    w_rty = 1'b0;
    w_dat = '0;
    for (int j = 0; j < SLAVES; j++) begin
      w_ack = w_ack | (w_sel[j] & s_ack_i[j]);
      w_err = w_err | (w_sel[j] & s_err_i[j]);
      w_rty = w_rty | (w_sel[j] & s_rty_i[j]);
      w_dat = w_dat | ({DATA_WIDTH{w_sel[j]}}
                       & s_dat_i[j*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign w_resp = w_ack | w_err | w_rty;
  assign w_fire = TO_EN && (r_state == BUSY) && w_req
                  && !w_resp && (r_cnt == TO_MAX);
  assign w_berr = ((r_state == DECERR) || (r_state == ABORT)) && w_req;

  assign s_cyc_o   = {SLAVES{rst_ni & m_cyc_i}} & w_sel;
  assign s_stb_o   = {SLAVES{rst_ni & m_stb_i}} & w_sel;
  assign m_dat_o   = w_dat;
  assign m_ack_o   = rst_ni & w_ack;
  assign m_rty_o   = rst_ni & w_rty;
  assign m_err_o   = rst_ni & (w_err | w_fire | w_berr);
  assign timeout_o = rst_ni & w_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_sel_q <= '0;
      r_cnt   <= '0;
    end else if (!m_cyc_i) begin
      r_state <= IDLE;
      r_sel_q <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_sel_q <= '0;
          r_cnt   <= '0;
          if (w_req && |w_dec) begin
            r_state <= BUSY;
            r_sel_q <= w_dec;
            // The first request cycle already counts as one wait.
            if (!w_resp) r_cnt <= CW'(1);
          end else if (w_req) begin
            r_state <= DECERR;
          end
        end
        BUSY: begin
          if (w_fire) begin
            r_state <= ABORT;
            r_cnt   <= '0;
          end else if (!m_stb_i || w_resp) begin
            r_cnt <= '0;
          end else if (r_cnt != TO_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DECERR: r_cnt <= '0;
        ABORT:  r_cnt <= '0;
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_decode.sv
// Directed bench for wb_decode: decode table, decode error,
// watchdog, burst hold and async reset.
module tb_wb_decode;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW >> 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [AW-1:0]     m_adr_i;
  logic [DW-1:0]     m_dat_i;
  logic [SW-1:0]     m_sel_i;
  logic              m_cyc_i, m_stb_i, m_we_i;
  logic [2:0]        m_cti_i;
  logic [1:0]        m_bte_i;
  logic [DW-1:0]     m_dat_o;
  logic              m_ack_o, m_err_o, m_rty_o;
  logic [AW*NS-1:0]  s_adr_o;
  logic [DW*NS-1:0]  s_dat_o;
  logic [SW*NS-1:0]  s_sel_o;
  logic [NS-1:0]     s_we_o;
  logic [3*NS-1:0]   s_cti_o;
  logic [2*NS-1:0]   s_bte_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic [DW*NS-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;
  logic              timeout_o;

  int checks = 0;
  int errors = 0;

  wb_decode #(
    .SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .S_BASE({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .S_MASK({3{32'hF000_0000}}),
    .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  ack;
    logic [2:0]  ecyc;
    logic        eack;
    logic        eerr;
    logic [31:0] edat;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic go();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    go();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    s_ack_i = '0;
    m_cti_i = 3'b000;
  endtask

  task automatic req(input logic [31:0] a);
    m_adr_i = a;
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
  endtask

  initial begin
    vt[0] = '{32'h1000_0004, 3'b010, 3'b010, 1'b1, 1'b0, 32'h2222_2222};
    vt[1] = '{32'h2000_0000, 3'b100, 3'b100, 1'b1, 1'b0, 32'h1234_5678};
    vt[2] = '{32'h0000_0010, 3'b000, 3'b001, 1'b0, 1'b0, 32'h1111_1111};
    vt[3] = '{32'h3000_0000, 3'b111, 3'b000, 1'b0, 1'b0, 32'h0};
    vt[4] = '{32'h2FFF_FFFF, 3'b011, 3'b100, 1'b0, 1'b0, 32'h1234_5678};
    vt[5] = '{32'hF000_0000, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0};

    rst_ni  = 1'b0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    m_cti_i = '0;
    m_bte_i = '0;
    s_dat_i = {32'h1234_5678, 32'h2222_2222, 32'h1111_1111};
    s_ack_i = '0;
    s_err_i = '0;
    s_rty_i = '0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_cyc", s_cyc_o, 3'b000);
    chk("rst_err", m_err_o, 1'b0);
    chk("rst_to", timeout_o, 1'b0);
    go();
    rst_ni = 1'b1;

    // Single-beat decode table, each applied from IDLE.
    for (int i = 0; i < 6; i++) begin
      go();
      req(vt[i].adr);
      s_ack_i = vt[i].ack;
      @(negedge clk_i);
      chk($sformatf("tab%0d_cyc", i), s_cyc_o, vt[i].ecyc);
      chk($sformatf("tab%0d_stb", i), s_stb_o, vt[i].ecyc);
      chk($sformatf("tab%0d_ack", i), m_ack_o, vt[i].eack);
      chk($sformatf("tab%0d_err", i), m_err_o, vt[i].eerr);
      chk($sformatf("tab%0d_dat", i), m_dat_o, vt[i].edat);
      idle();
    end

    // Write to slave 1, ack in cycle 2.
    go();
    req(32'h1000_0004);
    m_we_i  = 1'b1;
    m_dat_i = 32'hDEAD_BEEF;
    m_sel_i = 4'hF;
    @(negedge clk_i);
    chk("wr_c0_cyc", s_cyc_o, 3'b010);
    chk("wr_c0_dat", s_dat_o, {3{32'hDEAD_BEEF}});
    chk("wr_c0_we", s_we_o, 3'b111);
    chk("wr_c0_ack", m_ack_o, 1'b0);
    go();
    @(negedge clk_i);
    chk("wr_c1_cyc", s_cyc_o, 3'b010);
    chk("wr_c1_ack", m_ack_o, 1'b0);
    go();
    s_ack_i = 3'b010;
    @(negedge clk_i);
    chk("wr_c2_ack", m_ack_o, 1'b1);
    chk("wr_c2_stb", s_stb_o, 3'b010);
    idle();

    // Unmapped access: err from cycle 1 on every strobed beat.
    go();
    req(32'h3000_0000);
    @(negedge clk_i);
    chk("de_c0_err", m_err_o, 1'b0);
    chk("de_c0_cyc", s_cyc_o, 3'b000);
    go();
    @(negedge clk_i);
    chk("de_c1_err", m_err_o, 1'b1);
    chk("de_c1_cyc", s_cyc_o, 3'b000);
    go();
    m_stb_i = 1'b0;
    @(negedge clk_i);
    chk("de_nostb_err", m_err_o, 1'b0);
    go();
    m_stb_i = 1'b1;
    @(negedge clk_i);
    chk("de_beat2_err", m_err_o, 1'b1);
    idle();
    go();
    req(32'h0000_0000);
    @(negedge clk_i);
    chk("de_redec_cyc", s_cyc_o, 3'b001);
    chk("de_redec_err", m_err_o, 1'b0);
    idle();

    // Slave 0 never answers: timeout in cycle 8.
    go();
    req(32'h0000_0100);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      chk($sformatf("to_c%0d_err", c), m_err_o, 1'b0);
      chk($sformatf("to_c%0d_to", c), timeout_o, 1'b0);
      go();
    end
    @(negedge clk_i);
    chk("to_c8_err", m_err_o, 1'b1);
    chk("to_c8_to", timeout_o, 1'b1);
    chk("to_c8_cyc", s_cyc_o, 3'b001);
    go();
    @(negedge clk_i);
    chk("to_c9_cyc", s_cyc_o, 3'b000);
    chk("to_c9_err", m_err_o, 1'b1);
    chk("to_c9_to", timeout_o, 1'b0);
    idle();

    // Ack exactly at the threshold wins over the watchdog.
    go();
    req(32'h0000_0200);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      go();
    end
    s_ack_i = 3'b001;
    @(negedge clk_i);
    chk("ta_c8_ack", m_ack_o, 1'b1);
    chk("ta_c8_err", m_err_o, 1'b0);
    chk("ta_c8_to", timeout_o, 1'b0);
    go();
    s_ack_i = 3'b000;
    @(negedge clk_i);
    chk("ta_c9_cyc", s_cyc_o, 3'b001);
    chk("ta_c9_to", timeout_o, 1'b0);
    chk("ta_c9_err", m_err_o, 1'b0);
    idle();

    // Incrementing burst crossing into slave 1's window.
    go();
    req(32'h0FFF_FFF8);
    m_cti_i = 3'b010;
    s_ack_i = 3'b001;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        go();
        m_adr_i = 32'h0FFF_FFF8 + 32'(4 * b);
        if (b == 3) m_cti_i = 3'b111;
      end
      @(negedge clk_i);
      chk($sformatf("bu_b%0d_cyc", b), s_cyc_o, 3'b001);
      chk($sformatf("bu_b%0d_ack", b), m_ack_o, 1'b1);
      if (b == 1) chk("bu_cti", s_cti_o, {3{3'b010}});
    end
    idle();

    // Asynchronous reset in the middle of a burst.
    go();
    req(32'h0000_0000);
    s_ack_i = 3'b001;
    @(negedge clk_i);
    chk("rs_pre_ack", m_ack_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rs_cyc", s_cyc_o, 3'b000);
    chk("rs_stb", s_stb_o, 3'b000);
    chk("rs_ack", m_ack_o, 1'b0);
    chk("rs_err", m_err_o, 1'b0);
    go();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rs_post_cyc", s_cyc_o, 3'b001);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
